// File: rtl/ped_pkg.sv
// ped_pkg: lamp codes shared with the vehicle lamp stage and crossing state encoding
package ped_pkg;
  typedef logic [0:2] lamp_t;
  localparam lamp_t RED = 3'b100;
  localparam lamp_t GREEN = 3'b010;
  localparam lamp_t YELLOW = 3'b001;
  typedef enum logic [2:0] {IDLE, CLEAR, WALK, FLASH, FAULT} state_t;
  function automatic logic lamp_legal(input lamp_t v);
    return v == RED || v == GREEN || v == YELLOW;
  endfunction
endpackage

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian walk/don't-walk sequencer slaved to the vehicle lamp
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned WALK_CYCLES = 8,
  parameter int unsigned FLASH_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:2] veh_light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       wait_lamp,
  output logic       fault
);
  state_t state;
  logic [7:0] count;
  lamp_t prev_light;
  logic red_entry, req, trip;
  assign red_entry = veh_light == RED && prev_light != RED;
  assign req = wait_lamp || ped_btn;
  // any illegal code, or losing RED while pedestrians may be crossing, is unrecoverable
  assign trip = !lamp_legal(veh_light) || state == FAULT ||
                (veh_light != RED && state inside {CLEAR, WALK, FLASH});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      prev_light <= RED;
      walk <= 1'b0;
      dont_walk <= 1'b1;
      wait_lamp <= 1'b0;
      fault <= 1'b0;
    end else begin
      prev_light <= veh_light;
      if (trip) begin
        state <= FAULT;
        count <= '0;
        walk <= 1'b0;
        dont_walk <= 1'b1;
        wait_lamp <= 1'b0;
        fault <= 1'b1;
      end else begin
        if (ped_btn) wait_lamp <= 1'b1;
        case (state)
          IDLE:
            if (red_entry && req) begin
              state <= CLEAR;
              count <= 8'(CLEAR_CYCLES - 1);
            end
          CLEAR:
            if (count == 0) begin
              state <= WALK;
              count <= 8'(WALK_CYCLES - 1);
              walk <= 1'b1;
              dont_walk <= 1'b0;
              wait_lamp <= 1'b0;
            end else count <= count - 8'd1;
          WALK:
            if (count == 0) begin
              state <= FLASH;
              count <= 8'(FLASH_CYCLES - 1);
              walk <= 1'b0;
              dont_walk <= 1'b1;
            end else count <= count - 8'd1;
          FLASH:
            if (count == 0) begin
              state <= IDLE;
              dont_walk <= 1'b1;
            end else begin
              count <= count - 8'd1;
              dont_walk <= !dont_walk;
            end
          default: state <= FAULT;
        endcase
      end
    end
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed scoreboard bench for the pedestrian crossing controller
module tb_ped_crossing_ctrl;
  import ped_pkg::*;
  logic clk = 1'b0, rst = 1'b1, ped_btn = 1'b0;
  logic [0:2] veh_light = RED;
  logic walk, dont_walk, wait_lamp, fault;
  logic [3:0] sb[$];
  int checks = 0, failures = 0;

  ped_crossing_ctrl dut (
    .clk(clk), .rst(rst), .veh_light(veh_light), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .wait_lamp(wait_lamp), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    got = {walk, dont_walk, wait_lamp, fault};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed={walk,dw,wait,fault}=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step(input logic [0:2] l, input logic b, input logic [3:0] exp, input string tag);
    @(negedge clk);
    veh_light = l;
    ped_btn = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    chk(tag, sb.pop_front());
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    veh_light = RED;
    ped_btn = 1'b0;
    #1 chk("reset", 4'b0100);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_state", 4'b0100);
    @(negedge clk);
    rst = 1'b0;
    // basic request served on the next red entry
    step(GREEN, 0, 4'b0100, "green_idle");
    step(GREEN, 1, 4'b0110, "press");
    step(GREEN, 0, 4'b0110, "pending");
    step(YELLOW, 0, 4'b0110, "yellow_pending");
    step(RED, 0, 4'b0110, "red_entry_clear");
    step(RED, 0, 4'b0110, "clear2");
    for (int i = 0; i < 8; i++) step(RED, 0, 4'b1000, "walk");
    for (int i = 0; i < 6; i++) step(RED, 0, {1'b0, i % 2 == 0, 2'b00}, "flash");
    step(RED, 0, 4'b0100, "back_idle");
    // three lamp rotations with no request
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) step(GREEN, 0, 4'b0100, "norq_green");
      for (int i = 0; i < 2; i++) step(YELLOW, 0, 4'b0100, "norq_yellow");
      for (int i = 0; i < 3; i++) step(RED, 0, 4'b0100, "norq_red");
    end
    // request during flash waits for the following red entry
    step(GREEN, 1, 4'b0110, "press2");
    step(YELLOW, 0, 4'b0110, "yellow2");
    step(RED, 0, 4'b0110, "clear2a");
    step(RED, 0, 4'b0110, "clear2b");
    for (int i = 0; i < 8; i++) step(RED, 0, 4'b1000, "walk2");
    for (int i = 0; i < 6; i++) step(RED, i == 2, {1'b0, i % 2 == 0, i >= 2, 1'b0}, "flash_press");
    step(RED, 0, 4'b0110, "idle_pending");
    for (int i = 0; i < 3; i++) step(RED, 0, 4'b0110, "held_red_no_walk");
    step(GREEN, 0, 4'b0110, "green_pending");
    step(YELLOW, 0, 4'b0110, "yellow_pending3");
    step(RED, 0, 4'b0110, "clear3a");
    step(RED, 0, 4'b0110, "clear3b");
    for (int i = 0; i < 8; i++) step(RED, 0, 4'b1000, "walk3");
    for (int i = 0; i < 6; i++) step(RED, 0, {1'b0, i % 2 == 0, 2'b00}, "flash3");
    step(RED, 0, 4'b0100, "idle3");
    // green during the third walk cycle
    step(GREEN, 1, 4'b0110, "press4");
    step(YELLOW, 0, 4'b0110, "yellow4");
    step(RED, 0, 4'b0110, "clear4a");
    step(RED, 0, 4'b0110, "clear4b");
    for (int i = 0; i < 3; i++) step(RED, 0, 4'b1000, "walk4");
    step(GREEN, 0, 4'b0101, "conflict_fault");
    step(RED, 1, 4'b0101, "fault_sticky_btn");
    step(YELLOW, 0, 4'b0101, "fault_sticky_y");
    step(RED, 0, 4'b0101, "fault_sticky_r");
    rst_pulse();
    // illegal lamp code in idle
    step(3'b110, 0, 4'b0101, "illegal_code");
    step(RED, 1, 4'b0101, "illegal_sticky");
    rst_pulse();
    // async reset mid-walk with red held
    step(GREEN, 1, 4'b0110, "press5");
    step(YELLOW, 0, 4'b0110, "yellow5");
    step(RED, 0, 4'b0110, "clear5a");
    step(RED, 0, 4'b0110, "clear5b");
    for (int i = 0; i < 4; i++) step(RED, 0, 4'b1000, "walk5");
    #3 rst = 1'b1;
    #1 chk("async_reset", 4'b0100);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(RED, 0, 4'b0100, "post_rst_red");
    step(RED, 1, 4'b0110, "post_rst_press");
    for (int i = 0; i < 2; i++) step(RED, 0, 4'b0110, "post_rst_no_walk");
    step(GREEN, 0, 4'b0110, "green6");
    step(YELLOW, 0, 4'b0110, "yellow6");
    step(RED, 0, 4'b0110, "clear6a");
    step(RED, 0, 4'b0110, "clear6b");
    step(RED, 0, 4'b1000, "walk6");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
